dual_issue_scheduler: RTL and testbench
=======================================

# dual_issue_scheduler

Dual-issue scheduler between fetch and the two execute lanes of the superscalar core. It buffers fetched 16-bit instruction pairs in a small in-order queue and checks the two oldest entries for register hazards each cycle. It issues both to lanes 0/1 when they are independent, otherwise only the oldest to lane 0. It also handles downstream stall and pipeline flush.

## Interface
- `DEPTH`, 6: queue capacity in instructions; even, ≥4.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous; discards queue and issue registers.
- `in_valid` input 1: fetch presents a pair.
- `in_instr0` input 16: older instruction of the pair.
- `in_instr1` input 16: younger instruction of the pair.
- `in_ready` output 1: queue accepts a pair this cycle.
- `issue_stall` input 1: lanes cannot accept; hold outputs.
- `iss0_valid` / `iss0_instr` output 1/16: lane 0, always the older instruction.
- `iss1_valid` / `iss1_instr` output 1/16: lane 1.
- `single_issue` output 1: last issue was single because of a hazard.

## Operation
- Field decode: dest = [10:8], src1 = [7:5], src2 = [4:2]. src2 is valid only when [11]==0.
- Hazard between head A and next B when any of the following hold:
  - A.dest==B.dest (WAW)
  - A.dest==B.src1 (RAW)
  - A.dest==B.src2 with B[11]==0 (RAW)
  - B.dest==A.src1 (WAR)
  - B.dest==A.src2 with A[11]==0 (WAR)
- Queue: circular buffer of DEPTH entries, with rd_ptr, wr_ptr and count (width clog2(DEPTH+1)). Pointers wrap modulo DEPTH.
- Push: when in_valid && in_ready, in_instr0 is written at wr_ptr and in_instr1 at wr_ptr+1. count increases by 2.
- in_ready = (DEPTH − count ≥ 2) && !flush. It is computed from the registered count only; a same-cycle pop does not raise it.
- Pop/issue on a cycle with !issue_stall:
  - count==0: both valids are 0; nothing popped.
  - count==1: issue head on lane 0 only; single_issue=0.
  - count≥2 and no hazard: issue both; pop 2; single_issue=0.
  - count≥2 and hazard: issue head only on lane 0; pop 1; single_issue=1.
- issue_stall=1: all issue registers hold, nothing is popped, and push continues per in_ready.
- Simultaneous push and pop: count_next = count + 2·push − pop_n.
- flush: clears count, pointers and both valids; a same-cycle push is ignored. flush has priority over push, pop and stall.
- Lane 1 is never valid without lane 0.

## Timing
- Reset values: in_ready=1, iss0_valid=0, iss1_valid=0, iss0_instr=0, iss1_instr=0, single_issue=0, and all pointers and counters are 0.
- Issue registers load at the clock edge. A pair pushed at edge N appears on the iss outputs after edge N+1, giving 1 cycle of latency on an empty queue.
- The outputs of an issue are valid for exactly one cycle per issue unless issue_stall holds them.
- Reset asserted mid-operation clears everything immediately, asynchronously. Release is synchronous to clk.
- Full queue: in_ready=0 while count > DEPTH−2. Fetch must hold in_valid and its data.

## Configuration
- `DUAL_ISSUE_SCHED_STATS_EN` defined: adds 32-bit wrapping counters with ports `stat_dual` (both lanes issued), `stat_single` (hazard splits) and `stat_stall` (cycles with issue_stall && pending issue). The counters clear on reset and are not cleared by flush.
- Undefined: these ports and counters do not exist. Functional behaviour is otherwise identical.

## Structure
- Shared package `core_pkg`:
  - `instr_t` (16-bit) and `reg_idx_t` (3-bit)
  - field position constants DEST_MSB/LSB, SRC1, SRC2 and IMM_BIT = 11
- Sub-module `issue_hazard_check`: purely combinational; takes A and B and outputs `hazard`. It holds the pairing rule so other units can reuse it.
- The queue and issue registers live in the top level.

## Test plan
- Independent pair: push 16'h014C / 16'h05DC. Expect lane0=014C and lane1=05DC in the same cycle, one cycle after the push, with single_issue=0.
- RAW split: push 16'h014C / 16'h0420. Expect cycle 1 lane0=014C only with single_issue=1; cycle 2 lane0=0420 only.
- Immediate exemption: push 16'h014C / 16'h0E04, where B[11]=1 and field [4:2] matches dest r1. Expect dual issue.
- Full and stall: hold issue_stall=1 and push 3 pairs with DEPTH=6. Expect in_ready=0 after the third push, outputs frozen, and no data lost. Release the stall and expect in-order drain.
- Flush: with 4 queued, assert flush together with in_valid. Expect valids 0 on the next cycle, count 0, and the pushed pair dropped.
- Async reset mid-drain: assert rst_n=0 between edges. Expect iss0_valid to fall immediately and in_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: instruction/register index types, field positions, decode helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package core_pkg;

    typedef logic [15:0] instr_t;
    typedef logic [2:0]  reg_idx_t;

    localparam int DEST_MSB = 10;
    localparam int DEST_LSB = 8;
    localparam int SRC1_MSB = 7;
    localparam int SRC1_LSB = 5;
    localparam int SRC2_MSB = 4;
    localparam int SRC2_LSB = 2;
    localparam int IMM_BIT  = 11;

    // Register-usage view of one instruction.
    typedef struct packed {
        reg_idx_t dest;
        reg_idx_t src1;
        reg_idx_t src2;
        logic     src2_vld;
    } reg_use_t;

    // When the immediate bit is set, bits [4:2] carry immediate data, not a register.
    function automatic reg_use_t decode_regs(input instr_t instr);
        reg_use_t r;
        r.dest     = instr[DEST_MSB:DEST_LSB];
        r.src1     = instr[SRC1_MSB:SRC1_LSB];
        r.src2     = instr[SRC2_MSB:SRC2_LSB];
        r.src2_vld = ~instr[IMM_BIT];
        return r;
    endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Pairing rule: flags WAW/RAW/WAR conflicts between older instr A and younger instr B.
// Latency: purely combinational.
// Backpressure: none; ports are instr_a, instr_b (16b each) in, hazard out.
module issue_hazard_check
    import core_pkg::*;
(
    input  logic [15:0] instr_a,
    input  logic [15:0] instr_b,
    output logic        hazard
);

    reg_use_t a;
    reg_use_t b;

    assign a = decode_regs(instr_a);
    assign b = decode_regs(instr_b);

    assign hazard = (a.dest == b.dest)                   // WAW
                  | (a.dest == b.src1)                   // RAW
                  | ((a.dest == b.src2) & b.src2_vld)    // RAW
                  | (b.dest == a.src1)                   // WAR
                  | ((b.dest == a.src2) & a.src2_vld);   // WAR

    // Opcode and low bits play no part in pairing.
    logic unused_bits;
    assign unused_bits = ^{instr_a[15:12], instr_a[1:0], instr_b[15:12], instr_b[1:0]};

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: in-order queue of fetched pairs, issues 2 if independent else 1 to lane 0.
// Latency: pair pushed at edge N is on iss outputs after edge N+1 (empty queue).
// Backpressure: in_ready from registered count; issue_stall freezes issue regs; flush wins over all.
// Ports: clk, rst_n, flush, in_valid/in_instr0/in_instr1/in_ready, issue_stall,
//        iss0_valid/iss0_instr, iss1_valid/iss1_instr, single_issue.
//        Optional DUAL_ISSUE_SCHED_STATS_EN adds stat_dual, stat_single, stat_stall (32b wrapping).
module dual_issue_scheduler
    import core_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_instr0,
    input  logic [15:0] in_instr1,
    output logic        in_ready,
    input  logic        issue_stall,
    output logic        iss0_valid,
    output logic [15:0] iss0_instr,
    output logic        iss1_valid,
    output logic [15:0] iss1_instr,
    output logic        single_issue
`ifdef DUAL_ISSUE_SCHED_STATS_EN
    ,
    output logic [31:0] stat_dual,
    output logic [31:0] stat_single,
    output logic [31:0] stat_stall
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    instr_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic [1:0]      pop_n;
    logic            dual;
    logic            split;
    logic            hazard;
    instr_t          head_instr;
    instr_t          next_instr;

    assign in_ready   = (count <= (DEPTH_C - TWO_C)) && !flush;
    assign push       = in_valid && in_ready;
    assign head_instr = mem[rd_ptr];
    assign next_instr = mem[ptr_add(rd_ptr, 1)];

    issue_hazard_check u_hazard (
        .instr_a (head_instr),
        .instr_b (next_instr),
        .hazard  (hazard)
    );

    // Issue decision from registered occupancy; a stall pops nothing.
    always_comb begin
        pop_n = 2'd0;
        dual  = 1'b0;
        split = 1'b0;
        if (!issue_stall) begin
            if (count >= TWO_C) begin
                if (hazard) begin
                    pop_n = 2'd1;
                    split = 1'b1;
                end else begin
                    pop_n = 2'd2;
                    dual  = 1'b1;
                end
            end else if (count == ONE_C) begin
                pop_n = 2'd1;
            end
        end
    end

    // Storage only; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]             <= in_instr0;
            mem[ptr_add(wr_ptr, 1)] <= in_instr1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            iss0_valid   <= 1'b0;
            iss0_instr   <= '0;
            iss1_valid   <= 1'b0;
            iss1_instr   <= '0;
            single_issue <= 1'b0;
        end else if (flush) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            iss0_valid   <= 1'b0;
            iss1_valid   <= 1'b0;
            single_issue <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_add(wr_ptr, 2);
            rd_ptr <= ptr_add(rd_ptr, int'(pop_n));
            count  <= count + (push ? TWO_C : '0) - CW'(pop_n);
            if (!issue_stall) begin
                iss0_valid   <= (pop_n != 2'd0);
                iss1_valid   <= dual;
                single_issue <= split;
                if (pop_n != 2'd0) iss0_instr <= head_instr;
                if (dual)          iss1_instr <= next_instr;
            end
        end
    end

`ifdef DUAL_ISSUE_SCHED_STATS_EN
    // Event counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_dual   <= '0;
            stat_single <= '0;
            stat_stall  <= '0;
        end else if (!flush) begin
            if (dual)                         stat_dual   <= stat_dual + 32'd1;
            if (split)                        stat_single <= stat_single + 32'd1;
            if (issue_stall && count != '0)   stat_stall  <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: hazard pairing, stall/full, flush, async reset.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: fetch holds in_valid and data while in_ready is low.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr0;
    logic [15:0] in_instr1;
    logic        in_ready;
    logic        issue_stall;
    logic        iss0_valid;
    logic [15:0] iss0_instr;
    logic        iss1_valid;
    logic [15:0] iss1_instr;
    logic        single_issue;
`ifdef DUAL_ISSUE_SCHED_STATS_EN
    logic [31:0] stat_dual;
    logic [31:0] stat_single;
    logic [31:0] stat_stall;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    dual_issue_scheduler #(.DEPTH(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_instr0    (in_instr0),
        .in_instr1    (in_instr1),
        .in_ready     (in_ready),
        .issue_stall  (issue_stall),
        .iss0_valid   (iss0_valid),
        .iss0_instr   (iss0_instr),
        .iss1_valid   (iss1_valid),
        .iss1_instr   (iss1_instr),
        .single_issue (single_issue)
`ifdef DUAL_ISSUE_SCHED_STATS_EN
        ,
        .stat_dual    (stat_dual),
        .stat_single  (stat_single),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; issue_stall = 1'b0;
        in_instr0 = '0; in_instr1 = '0;
        #1;
        total_cnt++; if (in_ready !== 1'b1)     $display("FAIL rst_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (iss0_valid !== 1'b0)   $display("FAIL rst_v0 got %b want 0", iss0_valid); else pass_cnt++;
        total_cnt++; if (iss1_valid !== 1'b0)   $display("FAIL rst_v1 got %b want 0", iss1_valid); else pass_cnt++;
        total_cnt++; if (iss0_instr !== 16'h0)  $display("FAIL rst_i0 got %h want 0000", iss0_instr); else pass_cnt++;
        total_cnt++; if (iss1_instr !== 16'h0)  $display("FAIL rst_i1 got %h want 0000", iss1_instr); else pass_cnt++;
        total_cnt++; if (single_issue !== 1'b0) $display("FAIL rst_single got %b want 0", single_issue); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total_cnt++; if (iss0_valid !== 1'b0)   $display("FAIL rst_idle_v0 got %b want 0", iss0_valid); else pass_cnt++;
    endtask

    task automatic test_independent();
        in_valid = 1'b1; in_instr0 = 16'h014C; in_instr1 = 16'h05DC;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (iss0_valid !== 1'b0) $display("FAIL ind_early_v0 got %b want 0", iss0_valid); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C) $display("FAIL ind_l0 got %b/%h want 1/014C", iss0_valid, iss0_instr); else pass_cnt++;
        total_cnt++; if (iss1_valid !== 1'b1 || iss1_instr !== 16'h05DC) $display("FAIL ind_l1 got %b/%h want 1/05DC", iss1_valid, iss1_instr); else pass_cnt++;
        total_cnt++; if (single_issue !== 1'b0) $display("FAIL ind_single got %b want 0", single_issue); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b0 || iss1_valid !== 1'b0) $display("FAIL ind_oneshot got %b%b want 00", iss0_valid, iss1_valid); else pass_cnt++;
    endtask

    task automatic test_raw_split();
        in_valid = 1'b1; in_instr0 = 16'h014C; in_instr1 = 16'h0420;
        tick();
        in_valid = 1'b0;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C) $display("FAIL raw_c1_l0 got %b/%h want 1/014C", iss0_valid, iss0_instr); else pass_cnt++;
        total_cnt++; if (iss1_valid !== 1'b0) $display("FAIL raw_c1_v1 got %b want 0", iss1_valid); else pass_cnt++;
        total_cnt++; if (single_issue !== 1'b1) $display("FAIL raw_c1_single got %b want 1", single_issue); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h0420) $display("FAIL raw_c2_l0 got %b/%h want 1/0420", iss0_valid, iss0_instr); else pass_cnt++;
        total_cnt++; if (iss1_valid !== 1'b0 || single_issue !== 1'b0) $display("FAIL raw_c2_v1s got %b%b want 00", iss1_valid, single_issue); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b0) $display("FAIL raw_idle got %b want 0", iss0_valid); else pass_cnt++;
    endtask

    // {A, B, expect_dual}: immediate exemption on B, WAW, immediate exemption on A, WAR via A.src2.
    task automatic test_hazard_rules();
        logic [15:0] va [4] = '{16'h014C, 16'h014C, 16'h0A0C, 16'h020C};
        logic [15:0] vb [4] = '{16'h0E04, 16'h01E0, 16'h0320, 16'h0320};
        logic        vd [4] = '{1'b1,     1'b0,     1'b1,     1'b0};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_instr0 = va[k]; in_instr1 = vb[k];
            tick();
            in_valid = 1'b0;
            tick();
            total_cnt++;
            if (iss0_valid !== 1'b1 || iss0_instr !== va[k] || iss1_valid !== vd[k] || single_issue !== ~vd[k])
                $display("FAIL haz%0d got v0=%b i0=%h v1=%b s=%b want v0=1 i0=%h v1=%b s=%b",
                         k, iss0_valid, iss0_instr, iss1_valid, single_issue, va[k], vd[k], ~vd[k]);
            else pass_cnt++;
            if (vd[k]) begin
                total_cnt++; if (iss1_instr !== vb[k]) $display("FAIL haz%0d_i1 got %h want %h", k, iss1_instr, vb[k]); else pass_cnt++;
            end else begin
                tick();
                total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== vb[k]) $display("FAIL haz%0d_b got %b/%h want 1/%h", k, iss0_valid, iss0_instr, vb[k]); else pass_cnt++;
            end
            tick();
            tick();
        end
    endtask

    task automatic test_full_stall();
        issue_stall = 1'b1;
        in_valid = 1'b1; in_instr0 = 16'h014C; in_instr1 = 16'h05DC;
        tick();
        total_cnt++; if (in_ready !== 1'b1 || iss0_valid !== 1'b0) $display("FAIL full_p1 got rdy=%b v0=%b want 1/0", in_ready, iss0_valid); else pass_cnt++;
        in_instr0 = 16'h014C; in_instr1 = 16'h0E04;
        tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_p2 got rdy=%b want 1", in_ready); else pass_cnt++;
        in_instr0 = 16'h014C; in_instr1 = 16'h0420;
        tick();
        total_cnt++; if (in_ready !== 1'b0 || iss0_valid !== 1'b0) $display("FAIL full_p3 got rdy=%b v0=%b want 0/0", in_ready, iss0_valid); else pass_cnt++;
        in_instr0 = 16'h014C; in_instr1 = 16'h05DC;
        tick();
        total_cnt++; if (in_ready !== 1'b0 || iss0_valid !== 1'b0) $display("FAIL full_hold got rdy=%b v0=%b want 0/0", in_ready, iss0_valid); else pass_cnt++;
        issue_stall = 1'b0;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C || iss1_valid !== 1'b1 || iss1_instr !== 16'h05DC)
            $display("FAIL drain1 got %b/%h %b/%h want 1/014C 1/05DC", iss0_valid, iss0_instr, iss1_valid, iss1_instr); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL drain1_rdy got %b want 1", in_ready); else pass_cnt++;
        issue_stall = 1'b1;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C || iss1_valid !== 1'b1 || iss1_instr !== 16'h05DC)
            $display("FAIL frozen got %b/%h %b/%h want 1/014C 1/05DC", iss0_valid, iss0_instr, iss1_valid, iss1_instr); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL refill_rdy got %b want 0", in_ready); else pass_cnt++;
        issue_stall = 1'b0;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C || iss1_valid !== 1'b1 || iss1_instr !== 16'h0E04)
            $display("FAIL drain2 got %b/%h %b/%h want 1/014C 1/0E04", iss0_valid, iss0_instr, iss1_valid, iss1_instr); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C || iss1_valid !== 1'b0 || single_issue !== 1'b1)
            $display("FAIL drain3 got %b/%h v1=%b s=%b want 1/014C v1=0 s=1", iss0_valid, iss0_instr, iss1_valid, single_issue); else pass_cnt++;
        tick();
        // 0420 writes r4... and the next entry (014C) writes r1, which 0420 reads: WAR split.
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h0420 || iss1_valid !== 1'b0 || single_issue !== 1'b1)
            $display("FAIL drain4 got %b/%h v1=%b s=%b want 1/0420 v1=0 s=1", iss0_valid, iss0_instr, iss1_valid, single_issue); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C || iss1_valid !== 1'b1 || iss1_instr !== 16'h05DC || single_issue !== 1'b0)
            $display("FAIL drain5 got %b/%h %b/%h s=%b want 1/014C 1/05DC s=0", iss0_valid, iss0_instr, iss1_valid, iss1_instr, single_issue); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b0 || iss1_valid !== 1'b0) $display("FAIL drain_empty got %b%b want 00", iss0_valid, iss1_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr0 = 16'h014C; in_instr1 = 16'h05DC;
        tick();
        in_instr0 = 16'h0A0C; in_instr1 = 16'h0320;
        tick();
        total_cnt++; if (iss0_instr !== 16'h014C || iss1_instr !== 16'h05DC || iss1_valid !== 1'b1 || in_ready !== 1'b1)
            $display("FAIL b2b_1 got %h/%h v1=%b rdy=%b want 014C/05DC v1=1 rdy=1", iss0_instr, iss1_instr, iss1_valid, in_ready); else pass_cnt++;
        in_instr0 = 16'h014C; in_instr1 = 16'h0E04;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (iss0_instr !== 16'h0A0C || iss1_instr !== 16'h0320 || iss1_valid !== 1'b1)
            $display("FAIL b2b_2 got %h/%h v1=%b want 0A0C/0320 v1=1", iss0_instr, iss1_instr, iss1_valid); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_instr !== 16'h014C || iss1_instr !== 16'h0E04 || iss1_valid !== 1'b1)
            $display("FAIL b2b_3 got %h/%h v1=%b want 014C/0E04 v1=1", iss0_instr, iss1_instr, iss1_valid); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", iss0_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr0 = 16'h014C; in_instr1 = 16'h05DC;
        tick();
        in_instr0 = 16'h014C; in_instr1 = 16'h0E04;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1 || iss0_instr !== 16'h014C) $display("FAIL fl_pre got %b/%h want 1/014C", iss0_valid, iss0_instr); else pass_cnt++;
        issue_stall = 1'b1;
        in_instr0 = 16'h0E04; in_instr1 = 16'h05DC;
        tick();
        flush = 1'b1; in_instr0 = 16'h0A0C; in_instr1 = 16'h0320;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL fl_rdy_low got %b want 0", in_ready); else pass_cnt++;
        tick();
        flush = 1'b0; in_valid = 1'b0; issue_stall = 1'b0;
        #1;
        total_cnt++; if (iss0_valid !== 1'b0 || iss1_valid !== 1'b0) $display("FAIL fl_valids got %b%b want 00", iss0_valid, iss1_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL fl_rdy got %b want 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (iss0_valid !== 1'b0 || iss1_valid !== 1'b0) $display("FAIL fl_dropped got %b%b want 00", iss0_valid, iss1_valid); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_instr0 = 16'h014C; in_instr1 = 16'h0420;
        tick();
        in_valid = 1'b0;
        tick();
        total_cnt++; if (iss0_valid !== 1'b1) $display("FAIL ar_pre got %b want 1", iss0_valid); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (iss0_valid !== 1'b0 || iss0_instr !== 16'h0 || single_issue !== 1'b0)
            $display("FAIL ar_clear got v0=%b i0=%h s=%b want 0/0000/0", iss0_valid, iss0_instr, single_issue); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL ar_rdy got %b want 1", in_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total_cnt++; if (iss0_valid !== 1'b0) $display("FAIL ar_post got %b want 0", iss0_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_split();
        test_hazard_rules();
        test_full_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
